// File: rtl/mmul_sequencer.sv
// Sequencer for one tiled matrix multiply: streams A/B row pairs into the
// systolic array, waits for it to drain, then writes the NxN result tile back.
module mmul_sequencer #(
    parameter int N      = 4,
    parameter int ADDR_W = 8,
    parameter int DRAIN  = 3*N-2,
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_a_i,
    input  logic [ADDR_W-1:0] base_b_i,
    input  logic [ADDR_W-1:0] base_c_i,
    input  logic [ADDR_W-1:0] k_len_i,
    input  logic              stall_i,
    input  logic              last_i,
    output logic              valid_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_a_o,
    output logic [ADDR_W-1:0] addr_b_o,
    output logic              we_c_o,
    output logic [ADDR_W-1:0] addr_c_o,
    output logic [ROW_W-1:0]  row_sel_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int DRAIN_W = (DRAIN > 1) ? $clog2(DRAIN + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LAST,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   beat_q, beat_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [ADDR_W-1:0]   base_a_q, base_b_q, base_c_q, k_len_q;
    logic                cfg_load;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat/row/drain counters and the command captured at start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q   <= '0;
            row_q    <= '0;
            drain_q  <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            k_len_q  <= '0;
        end else begin
            beat_q  <= beat_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            if (cfg_load) begin
                base_a_q <= base_a_i;
                base_b_q <= base_b_i;
                base_c_q <= base_c_i;
                k_len_q  <= k_len_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        row_d     = row_q;
        drain_d   = drain_q;
        cfg_load  = 1'b0;
        valid_o   = 1'b0;
        we_o      = 1'b0;
        addr_a_o  = '0;
        addr_b_o  = '0;
        we_c_o    = 1'b0;
        addr_c_o  = '0;
        row_sel_o = '0;
        busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
        done_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cfg_load = 1'b1;
                    beat_d   = '0;
                    row_d    = '0;
                    drain_d  = '0;
                    state_d  = (k_len_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall_i) begin
                    valid_o  = 1'b1;
                    addr_a_o = base_a_q + beat_q;
                    addr_b_o = base_b_q + beat_q;
                    if (beat_q == k_len_q - ADDR_W'(1)) begin
                        // A last_i coinciding with the final beat skips WAIT_LAST.
                        we_o    = 1'b1;
                        beat_d  = '0;
                        state_d = last_i ? S_DRAIN : S_WAIT_LAST;
                    end else begin
                        beat_d = beat_q + ADDR_W'(1);
                    end
                end
            end
            S_WAIT_LAST: begin
                if (last_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN - 1)) begin
                    drain_d = '0;
                    state_d = S_WRITE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            S_WRITE: begin
                if (!stall_i) begin
                    we_c_o    = 1'b1;
                    addr_c_o  = base_c_q + ADDR_W'(row_q);
                    row_sel_o = row_q;
                    if (row_q == ROW_W'(N - 1)) begin
                        row_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mmul_sequencer.sv
// Randomized bench for mmul_sequencer; a cycle-level transaction model predicts
// every output from beat/row counts and the last_i/stall history it drives.
module tb_mmul_sequencer;

    localparam int N      = 4;
    localparam int ADDR_W = 8;
    localparam int DRAIN  = 3*N-2;

    logic              clk = 1'b0;
    logic              rst_i, start_i, stall_i, last_i;
    logic [ADDR_W-1:0] base_a_i, base_b_i, base_c_i, k_len_i;
    logic              valid_o, we_o, we_c_o, busy_o, done_o;
    logic [ADDR_W-1:0] addr_a_o, addr_b_o, addr_c_o;
    logic [1:0]        row_sel_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mmul_sequencer #(.N(N), .ADDR_W(ADDR_W), .DRAIN(DRAIN)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .base_a_i(base_a_i), .base_b_i(base_b_i), .base_c_i(base_c_i),
        .k_len_i(k_len_i), .stall_i(stall_i), .last_i(last_i),
        .valid_o(valid_o), .we_o(we_o), .addr_a_o(addr_a_o), .addr_b_o(addr_b_o),
        .we_c_o(we_c_o), .addr_c_o(addr_c_o), .row_sel_o(row_sel_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".valid"},   32'(valid_o),   32'd0);
        checkOutput({tag, ".we"},      32'(we_o),      32'd0);
        checkOutput({tag, ".addr_a"},  32'(addr_a_o),  32'd0);
        checkOutput({tag, ".addr_b"},  32'(addr_b_o),  32'd0);
        checkOutput({tag, ".we_c"},    32'(we_c_o),    32'd0);
        checkOutput({tag, ".addr_c"},  32'(addr_c_o),  32'd0);
        checkOutput({tag, ".row_sel"}, 32'(row_sel_o), 32'd0);
        checkOutput({tag, ".busy"},    32'(busy_o),    32'd0);
        checkOutput({tag, ".done"},    32'(done_o),    32'd0);
    endtask

    // One command from start strobe to done pulse (or to an abort by reset).
    // Cycle 0 is the start cycle; all expectations come from counts of
    // accepted beats/rows and the cycle last_i was delivered.
    task automatic applyStimulus(input string name,
                                 input logic [7:0] ba, input logic [7:0] bb,
                                 input logic [7:0] bc, input logic [7:0] k,
                                 input int gap, input bit rnd_stall,
                                 input int stall_from, input int stall_len,
                                 input int abort_row);
        int  kk, beats, rows, fb, lc, done_c;
        bit  st, lst, ev, fin, ewc, abort, done_now;
        logic [7:0] ea, eb, ec;
        kk = int'(k);
        beats = 0; rows = 0; fb = -1; lc = -1;
        done_c = (kk == 0) ? 1 : -1;
        for (int c = 0; c < 4000; c++) begin
            if (rnd_stall) st = ($urandom_range(0, 3) == 0);
            else           st = (c >= stall_from) && (c < stall_from + stall_len);
            ev  = (c >= 1) && (beats < kk) && !st;
            fin = ev && (beats == kk - 1);
            if (fin) fb = c;
            if (fb >= 0 && lc < 0 && c == fb + gap) lc = c;
            if (lc == c)                lst = 1'b1;
            else if (lc >= 0 && c > lc) lst = 1'($urandom_range(0, 1));
            else                        lst = 1'b0;
            ewc   = (lc >= 0) && (c >= lc + DRAIN + 1) && (rows < N) && !st;
            abort = (abort_row >= 0) && ewc && (rows == abort_row);

            start_i  = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            base_a_i = (c == 0) ? ba : 8'($urandom);
            base_b_i = (c == 0) ? bb : 8'($urandom);
            base_c_i = (c == 0) ? bc : 8'($urandom);
            k_len_i  = (c == 0) ? k  : 8'($urandom);
            stall_i  = st;
            last_i   = lst;
            rst_i    = abort;

            if (abort) begin
                @(posedge clk); #1;
                rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; last_i = 1'b0;
                @(negedge clk);
                checkIdle({name, ".after_reset"});
                @(posedge clk); #1;
                return;
            end

            ea = ev  ? 8'(ba + 8'(beats)) : 8'h00;
            eb = ev  ? 8'(bb + 8'(beats)) : 8'h00;
            ec = ewc ? 8'(bc + 8'(rows))  : 8'h00;
            done_now = (c == done_c);

            @(negedge clk);
            checkOutput({name, ".valid"},   32'(valid_o),   32'(ev));
            checkOutput({name, ".we"},      32'(we_o),      32'(fin));
            checkOutput({name, ".addr_a"},  32'(addr_a_o),  32'(ea));
            checkOutput({name, ".addr_b"},  32'(addr_b_o),  32'(eb));
            checkOutput({name, ".we_c"},    32'(we_c_o),    32'(ewc));
            checkOutput({name, ".addr_c"},  32'(addr_c_o),  32'(ec));
            checkOutput({name, ".row_sel"}, 32'(row_sel_o), ewc ? 32'(rows) : 32'd0);
            checkOutput({name, ".busy"},    32'(busy_o),
                        32'((c >= 1) && (done_c < 0 || c < done_c)));
            checkOutput({name, ".done"},    32'(done_o),    32'(done_now));

            if (ewc && rows == N - 1) done_c = c + 1;
            if (ev)  beats++;
            if (ewc) rows++;
            @(posedge clk); #1;
            if (done_now) return;
        end
        checkOutput({name, ".timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; last_i = 1'b0;
        base_a_i = '0; base_b_i = '0; base_c_i = '0; k_len_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        checkIdle("reset");
        @(posedge clk); #1;

        applyStimulus("basic",   8'h10, 8'h20, 8'h30, 8'd4, 2, 1'b0, 0, 0, -1);
        applyStimulus("stall",   8'h40, 8'h50, 8'h60, 8'd4, 1, 1'b0, 3, 3, -1);
        applyStimulus("klen0",   8'h11, 8'h22, 8'h33, 8'd0, 0, 1'b0, 0, 0, -1);
        applyStimulus("wrap",    8'hFE, 8'h05, 8'hFE, 8'd3, 0, 1'b0, 0, 0, -1);
        applyStimulus("klen1",   8'h7F, 8'hFF, 8'h01, 8'd1, 3, 1'b0, 0, 0, -1);
        applyStimulus("abort",   8'h01, 8'h02, 8'h03, 8'd5, 1, 1'b0, 0, 0, 2);
        applyStimulus("clean",   8'h21, 8'h31, 8'h41, 8'd5, 2, 1'b0, 0, 0, -1);
        applyStimulus("abort_r", 8'hA0, 8'hB0, 8'hC0, 8'd6, 0, 1'b1, 0, 0, 0);
        for (int t = 0; t < 14; t++) begin
            applyStimulus($sformatf("rand%0d", t), 8'($urandom), 8'($urandom),
                          8'($urandom), 8'($urandom_range(0, 12)),
                          int'($urandom_range(0, 4)), 1'b1, 0, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
